// File: rtl/sad_pkg.sv
// Shared constants, state type and pixel helper for the SAD accumulator.
package sad_pkg;

  localparam int unsigned LANES    = 16;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned ROWSAD_W = 12;
  localparam int unsigned SAD_W    = 16;
  localparam logic [SAD_W-1:0] SAD_INIT = 16'hFFFF;

  typedef enum logic {StIdle, StAccum} state_e;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sad_row16.sv
// Combinational sum of absolute differences across the 16 lanes of one row.
module sad_row16
  import sad_pkg::*;
(
  input  logic [LANES*PIX_W-1:0] a_row_i,
  input  logic [LANES*PIX_W-1:0] b_row_i,
  output logic [ROWSAD_W-1:0]    row_sad_o
);

  logic [ROWSAD_W-1:0] lane_diff [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_diff[i] = ROWSAD_W'(abs_diff(a_row_i[i*PIX_W +: PIX_W], b_row_i[i*PIX_W +: PIX_W]));
    end
  end

  // 16 * 255 = 4080 fits in 12 bits, so the running sum never truncates.
  always_comb begin
    row_sad_o = '0;
    for (int i = 0; i < LANES; i++) begin
      row_sad_o = row_sad_o + lane_diff[i];
    end
  end

endmodule

// File: rtl/sad_accum.sv
// Two-stage block SAD accumulator with running minimum over a candidate search.
module sad_accum
  import sad_pkg::*;
#(
  parameter int unsigned ROWS   = 16,
  parameter int unsigned CAND_W = 10
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
  input  logic                   InValid,
  input  logic [LANES*PIX_W-1:0] A_row,
  input  logic [LANES*PIX_W-1:0] B_row,
  input  logic                   LastCand,
  output logic [SAD_W-1:0]       BlkSad,
  output logic                   BlkValid,
  output logic [SAD_W-1:0]       MinSad,
  output logic [CAND_W-1:0]      MinIdx,
  output logic                   Done,
  output logic                   Busy
);

  localparam logic [3:0] LastRow = 4'(ROWS - 1);

  state_e              state_q, state_d;
  logic [3:0]          row_cnt_q, row_cnt_d;
  logic [CAND_W-1:0]   cand_q, cand_d;
  logic [SAD_W-1:0]    acc_q, acc_d;
  logic                s1_valid_q, s1_valid_d;
  logic [ROWSAD_W-1:0] s1_sad_q, s1_sad_d;
  logic                s1_last_q, s1_last_d;
  logic                s1_lc_q, s1_lc_d;
  logic [SAD_W-1:0]    blk_sad_q, blk_sad_d;
  logic                blk_valid_q, blk_valid_d;
  logic [SAD_W-1:0]    min_sad_q, min_sad_d;
  logic [CAND_W-1:0]   min_idx_q, min_idx_d;
  logic                done_q, done_d;

  logic [ROWSAD_W-1:0] row_sad;
  logic [SAD_W-1:0]    total;

  sad_row16 u_row (
    .a_row_i  (A_row),
    .b_row_i  (B_row),
    .row_sad_o(row_sad)
  );

  assign total = acc_q + SAD_W'(s1_sad_q);

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    cand_d      = cand_q;
    acc_d       = acc_q;
    s1_valid_d  = 1'b0;
    s1_sad_d    = s1_sad_q;
    s1_last_d   = s1_last_q;
    s1_lc_d     = s1_lc_q;
    blk_sad_d   = blk_sad_q;
    blk_valid_d = 1'b0;
    min_sad_d   = min_sad_q;
    min_idx_d   = min_idx_q;
    done_d      = 1'b0;

    if (Start) begin
      // A new search discards any in-flight row, including one offered alongside Start.
      state_d   = StAccum;
      row_cnt_d = '0;
      cand_d    = '0;
      acc_d     = '0;
      min_sad_d = SAD_INIT;
      min_idx_d = '0;
    end else begin
      if (state_q == StAccum && InValid) begin
        s1_valid_d = 1'b1;
        s1_sad_d   = row_sad;
        s1_last_d  = (row_cnt_q == LastRow);
        s1_lc_d    = LastCand;
        row_cnt_d  = (row_cnt_q == LastRow) ? 4'd0 : row_cnt_q + 4'd1;
      end

      if (s1_valid_q) begin
        if (s1_last_q) begin
          acc_d       = '0;
          blk_sad_d   = total;
          blk_valid_d = 1'b1;
          if (total < min_sad_q) begin
            min_sad_d = total;
            min_idx_d = cand_q;
          end
          cand_d = cand_q + CAND_W'(1);
          if (s1_lc_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else begin
          acc_d = total;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= StIdle;
      row_cnt_q   <= '0;
      cand_q      <= '0;
      acc_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sad_q    <= '0;
      s1_last_q   <= 1'b0;
      s1_lc_q     <= 1'b0;
      blk_sad_q   <= '0;
      blk_valid_q <= 1'b0;
      min_sad_q   <= SAD_INIT;
      min_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      cand_q      <= cand_d;
      acc_q       <= acc_d;
      s1_valid_q  <= s1_valid_d;
      s1_sad_q    <= s1_sad_d;
      s1_last_q   <= s1_last_d;
      s1_lc_q     <= s1_lc_d;
      blk_sad_q   <= blk_sad_d;
      blk_valid_q <= blk_valid_d;
      min_sad_q   <= min_sad_d;
      min_idx_q   <= min_idx_d;
      done_q      <= done_d;
    end
  end

  assign BlkSad   = blk_sad_q;
  assign BlkValid = blk_valid_q;
  assign MinSad   = min_sad_q;
  assign MinIdx   = min_idx_q;
  assign Done     = done_q;
  assign Busy     = (state_q == StAccum);

endmodule
